// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: rotating-pointer search, grant held until release or hold limit.
// Latency 1 cycle req->gnt; no backpressure, requesters keep req high until granted.
module rr_grant_sched #(
    parameter int WIDTH    = 8,
    parameter int LOG_W    = 3,
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] done,
    output logic [WIDTH-1:0] gnt,
    output logic [LOG_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic [LOG_W-1:0] ptr,
    output logic             preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit                HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [LOG_W-1:0]  LAST_IDX  = LOG_W'(WIDTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]  gnt_nxt;
    logic [LOG_W-1:0]  gnt_idx_nxt;
    logic              gnt_valid_nxt;
    logic [LOG_W-1:0]  ptr_nxt;
    logic              preempt_nxt;

    logic              win_found;
    logic [LOG_W-1:0]  win_idx;

    logic              rel_done;
    logic              rel_drop;
    logic              rel_hold;
    logic              release_now;
    logic [LOG_W-1:0]  ptr_adv;

    // Rotating search: first set request at or after ptr, wrapping through WIDTH-1 to 0.
    always_comb begin
        int j;
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int i = 0; i < WIDTH; i++) begin
            j = int'(ptr) + i;
            if (j >= WIDTH) begin
                j = j - WIDTH;
            end
            if (!win_found && req[j[LOG_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = j[LOG_W-1:0];
            end
        end
    end

    // Only the granted requester's done/req bits can end a grant.
    always_comb begin
        rel_done    = done[gnt_idx];
        rel_drop    = !req[gnt_idx];
        rel_hold    = HOLD_EN && (cnt == HOLD_LAST);
        release_now = rel_done || rel_drop || rel_hold;
        ptr_adv     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        gnt_nxt       = gnt;
        gnt_idx_nxt   = gnt_idx;
        gnt_valid_nxt = gnt_valid;
        ptr_nxt       = ptr;
        preempt_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt          = GRANT;
                    gnt_nxt            = '0;
                    gnt_nxt[win_idx]   = 1'b1;
                    gnt_idx_nxt        = win_idx;
                    gnt_valid_nxt      = 1'b1;
                    cnt_nxt            = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // Returning to IDLE forces the single bubble cycle between grants.
                    state_nxt     = IDLE;
                    gnt_nxt       = '0;
                    gnt_idx_nxt   = '0;
                    gnt_valid_nxt = 1'b0;
                    cnt_nxt       = '0;
                    ptr_nxt       = ptr_adv;
                    preempt_nxt   = rel_hold && !rel_done && !rel_drop;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= gnt_idx_nxt;
            gnt_valid <= gnt_valid_nxt;
            ptr       <= ptr_nxt;
            preempt   <= preempt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed bench for rr_grant_sched with a per-edge expectation queue and constant spot checks.
module tb_rr_grant_sched;

    localparam int W  = 8;
    localparam int LW = 3;
    localparam int HW = 8;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  req;
    logic [W-1:0]  done;
    logic [W-1:0]  gnt;
    logic [LW-1:0] gnt_idx;
    logic          gnt_valid;
    logic [LW-1:0] ptr;
    logic          preempt;

    always #5 clk = ~clk;

    rr_grant_sched #(
        .WIDTH   (W),
        .LOG_W   (LW),
        .HOLD_W  (HW),
        .MAX_HOLD(MH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .ptr      (ptr),
        .preempt  (preempt)
    );

    typedef struct packed {
        logic [W-1:0]  gnt;
        logic [LW-1:0] idx;
        logic          vld;
        logic [LW-1:0] ptr;
        logic          pre;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    bit   m_busy = 1'b0;
    int   m_idx  = 0;
    int   m_ptr  = 0;
    int   m_cnt  = 0;
    bit   m_pre  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Behavioural reference: what the outputs must be after one rising edge with these inputs.
    task automatic model_edge(input logic r, input logic [W-1:0] rq, input logic [W-1:0] dn);
        bit d;
        bit q;
        bit h;
        bit found;
        int c;
        m_pre = 1'b0;
        found = 1'b0;
        if (!r) begin
            m_busy = 1'b0;
            m_idx  = 0;
            m_ptr  = 0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < W; k++) begin
                c = (m_ptr + k) % W;
                if (!found && rq[c]) begin
                    found  = 1'b1;
                    m_busy = 1'b1;
                    m_idx  = c;
                    m_cnt  = 0;
                end
            end
        end else begin
            d = dn[m_idx];
            q = !rq[m_idx];
            h = (m_cnt == MH - 1);
            if (d || q || h) begin
                m_pre  = h && !d && !q;
                m_ptr  = (m_idx + 1) % W;
                m_busy = 1'b0;
                m_idx  = 0;
                m_cnt  = 0;
            end else if (m_cnt < (1 << HW) - 1) begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] rq, input logic [W-1:0] dn);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = dn;
        model_edge(r, rq, dn);
        e.gnt = m_busy ? (W'(1) << m_idx) : '0;
        e.idx = LW'(m_idx);
        e.vld = m_busy;
        e.ptr = LW'(m_ptr);
        e.pre = m_pre;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("gnt",       32'(gnt),       32'(e.gnt));
        chk("gnt_idx",   32'(gnt_idx),   32'(e.idx));
        chk("gnt_valid", 32'(gnt_valid), 32'(e.vld));
        chk("ptr",       32'(ptr),       32'(e.ptr));
        chk("preempt",   32'(preempt),   32'(e.pre));
    endtask

    initial begin
        int       hv;
        logic     saw_pre;
        logic [W-1:0] oh;
        rst  = 1'b0;
        req  = '0;
        done = '0;

        // Reset with all requests pending, then first grant on release of reset.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'hFF, 8'h00);
        end
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ptr", 32'(ptr), 32'h0);
        step(1'b1, 8'hFF, 8'h00);
        chk("first_gnt", 32'(gnt), 32'h01);

        // Fairness: done two cycles after each grant, one bubble between grants.
        for (int k = 0; k < W; k++) begin
            oh = 8'h01 << k;
            step(1'b1, 8'hFF, 8'h00);
            step(1'b1, 8'hFF, oh);
            chk("fair_bubble", 32'(gnt), 32'h0);
            chk("fair_ptr", 32'(ptr), 32'((k + 1) % W));
            step(1'b1, 8'hFF, 8'h00);
            oh = 8'h01 << ((k + 1) % W);
            chk("fair_gnt", 32'(gnt), 32'(oh));
        end

        // Move ptr to 6 via a grant to requester 5.
        step(1'b1, 8'h20, 8'h00);
        step(1'b1, 8'h20, 8'h00);
        step(1'b1, 8'h00, 8'h00);
        chk("setup_ptr6", 32'(ptr), 32'd6);

        // Wrap and skip from ptr 6.
        step(1'b1, 8'h21, 8'h00);
        chk("wrap_gnt0", 32'(gnt), 32'h01);
        step(1'b1, 8'h21, 8'h01);
        chk("wrap_ptr1", 32'(ptr), 32'd1);
        step(1'b1, 8'h21, 8'h00);
        chk("skip_gnt5", 32'(gnt), 32'h20);
        step(1'b1, 8'h21, 8'h20);
        chk("skip_ptr6", 32'(ptr), 32'd6);

        // Hold-limit preemption of a lone requester.
        step(1'b1, 8'h04, 8'h00);
        chk("pre_gnt", 32'(gnt), 32'h04);
        hv      = 1;
        saw_pre = 1'b0;
        for (int n = 0; n < 20 && gnt == 8'h04; n++) begin
            step(1'b1, 8'h04, 8'h00);
            if (gnt == 8'h04) hv++;
            else saw_pre = preempt;
        end
        chk("hold_cycles", 32'(hv), 32'd4);
        chk("preempt_pulse", 32'(saw_pre), 32'h1);
        chk("pre_ptr", 32'(ptr), 32'd3);
        step(1'b1, 8'h04, 8'h00);
        chk("regrant", 32'(gnt), 32'h04);
        chk("pre_cleared", 32'(preempt), 32'h0);

        // Request drop coinciding with hold limit: no preempt, stray done ignored.
        step(1'b1, 8'h04, 8'h00);
        step(1'b1, 8'h04, 8'h00);
        step(1'b1, 8'h04, 8'h00);
        step(1'b1, 8'h00, 8'h20);
        chk("drop_pre", 32'(preempt), 32'h0);
        chk("drop_ptr", 32'(ptr), 32'd3);
        step(1'b1, 8'h00, 8'h20);
        chk("idle_done", 32'(gnt), 32'h0);

        // Reset in the middle of a grant.
        step(1'b1, 8'h10, 8'h00);
        chk("mid_gnt", 32'(gnt), 32'h10);
        step(1'b1, 8'h10, 8'h01);
        chk("foreign_done", 32'(gnt), 32'h10);
        step(1'b0, 8'h10, 8'h00);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_ptr", 32'(ptr), 32'h0);
        step(1'b1, 8'h10, 8'h00);
        chk("post_rst_gnt", 32'(gnt), 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_grant_sched.md
Name: rr_grant_sched

Overview:
- Round-robin scheduler that shares one resource among WIDTH requesters.
- Picks one requester with a programmable-priority search that starts at a rotating pointer.
- Holds the grant until the winner releases, drops its request, or exceeds a hold limit.
- Then advances the pointer past the winner, giving rotating fairness; sits between requester ports and the shared datapath it gates.

Parameters:
- WIDTH, 8, number of requesters (>=2).
- LOG_W, 3, index width, clog2(WIDTH).
- HOLD_W, 8, hold-counter width.
- MAX_HOLD, 16, max grant cycles before preemption; 0 = unlimited; must be <= 2^HOLD_W-1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- req  in  WIDTH  request vector, level, one bit per requester.
- done  in  WIDTH  release pulse; only the currently granted bit is honoured.
- gnt  out  WIDTH  registered one-hot grant, all-zero when idle.
- gnt_idx  out  LOG_W  registered index of granted requester; 0 when idle.
- gnt_valid  out  1  registered; 1 when gnt is nonzero.
- ptr  out  LOG_W  registered current priority pointer (search start).
- preempt  out  1  registered 1-cycle pulse when a grant ends by hold limit.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, ptr=0, preempt=0, hold counter=0.
  - Reset overrides everything, including a grant in progress.
- State IDLE:
  - If req==0: outputs hold at 0, ptr unchanged.
  - Otherwise winner = first set req bit scanning ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1.
  - Next edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, cnt=0, state=GRANT.
  - Latency: req sampled at edge t gives gnt visible after edge t (one register stage).
- State GRANT: gnt, gnt_idx and ptr are held; cnt increments each cycle, saturating.
- A release fires on the first edge where any of these is true:
  - (a) done[gnt_idx]=1;
  - (b) req[gnt_idx]=0;
  - (c) MAX_HOLD!=0 and cnt==MAX_HOLD-1, i.e. the grant was visible for exactly MAX_HOLD cycles.
- On release, at that edge:
  - gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE.
  - ptr = (gnt_idx==WIDTH-1) ? 0 : gnt_idx+1.
  - preempt=1 only if (c) holds and neither (a) nor (b) does; otherwise preempt=0.
  - preempt is 0 on every other edge.
- Bubble: exactly one idle cycle (gnt=0) between consecutive grants, even with pending requests.
- Simultaneous events:
  - (a) and (b) together count as one release, no preempt.
  - done bits of non-granted requesters are ignored in every state.
  - done while IDLE is ignored.
- Changes to other req bits during GRANT do not affect the current grant.
- A preempted requester still requesting competes normally.
  - If it is the only requester, it is regranted after the bubble with ptr already advanced.
- Invariants: gnt is zero or one-hot; gnt_valid == |gnt; gnt_idx matches gnt.

Test Plan:
1. Reset: rst=0 for 3 cycles with req=8'hFF -> gnt=0, gnt_valid=0, ptr=0, preempt=0; rst=1 -> gnt=8'h01, gnt_idx=0 on the first edge with rst=1.
2. Fairness: req=8'hFF held, done[gnt_idx] pulsed 2 cycles after each grant -> grant order 01,02,04,...,80,01; ptr 1,2,...,7,0; one bubble between grants.
3. Wrap/skip: ptr=6, req=8'h21 -> gnt=8'h01 (idx0), ptr then 1; next grant 8'h20 (idx5), ptr then 6.
4. Preempt: MAX_HOLD=4, only req[2]=1, no done -> gnt=8'h04 for exactly 4 cycles; preempt pulses 1 cycle as gnt drops; ptr=3; gnt=8'h04 again after one bubble.
5. Release priority: granted idx2 drops req[2] while cnt==MAX_HOLD-1, done[5]=1 -> release, preempt=0, ptr=3, done[5] has no effect.
6. Reset mid-grant: gnt=8'h10 active, rst=0 one edge -> gnt=0, ptr=0, state IDLE; req=8'h10 on release of rst -> gnt=8'h10 one edge later.
